bcd_stopwatch_ctrl: RTL and testbench



---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit.sv | 25 ++
 rtl/bcd_stopwatch_ctrl.sv | 104 ++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM state encoding and BCD digit limits.
package bcd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t PAUSE = 2'd2;
    localparam state_t OVF   = 2'd3;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// Single BCD counter digit: synchronous clear, increment enable, wraps 9 -> 0.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] dig,
    output logic             at_max
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig <= '0;
        end else if (clr) begin
            dig <= '0;
        end else if (inc) begin
            dig <= (dig == BCD_MAX) ? '0 : dig + BCD_W'(1);
        end
    end

    assign at_max = (dig == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: prescaler, start/pause/clear/lap FSM, carry chain across NDIG
// BCD digits, overflow freeze and lap-hold display register.
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [BCD_W*NDIG-1:0] count_out,
    output logic [BCD_W*NDIG-1:0] disp_out,
    output logic                  running,
    output logic                  ovf,
    output logic                  tick_out,
    output state_t                state_dbg
);

    localparam int PW = $clog2(PRESCALE);

    state_t                  state;
    logic [PW-1:0]           presc;
    logic                    hold;
    logic [BCD_W*NDIG-1:0]   lap_reg;
    logic [NDIG-1:0]         at_max;
    logic [NDIG-1:0]         inc;
    logic                    all_max;
    logic                    tick;
    logic                    run_carry;

    assign tick    = (state == RUN) && (presc == PW'(PRESCALE - 1));
    assign all_max = &at_max;

    // Ripple the enable upward; a tick at all-nines must not wrap, it freezes into OVF.
    always_comb begin
        run_carry = tick & ~all_max;
        for (int i = 0; i < NDIG; i++) begin
            inc[i]    = run_carry;
            run_carry = run_carry & at_max[i];
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .clr    (clear),
            .inc    (inc[g]),
            .dig    (count_out[g*BCD_W +: BCD_W]),
            .at_max (at_max[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            presc   <= '0;
            hold    <= 1'b0;
            lap_reg <= '0;
        end else if (clear) begin
            state   <= IDLE;
            presc   <= '0;
            hold    <= 1'b0;
            lap_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_stop) begin
                        state <= RUN;
                        presc <= '0;
                    end
                end
                RUN: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick && all_max) state <= OVF;
                    else if (start_stop) state <= PAUSE;
                end
                PAUSE: begin
                    if (start_stop) state <= RUN;
                end
                default: ;
            endcase
            // start_stop outranks lap in the same cycle; lap only acts while counting or paused.
            if (lap && !start_stop && (state == RUN || state == PAUSE)) begin
                if (hold) begin
                    hold <= 1'b0;
                end else begin
                    hold    <= 1'b1;
                    lap_reg <= count_out;
                end
            end
        end
    end

    assign disp_out  = hold ? lap_reg : count_out;
    assign running   = (state == RUN);
    assign ovf       = (state == OVF);
    assign tick_out  = tick;
    assign state_dbg = state;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl (NDIG=2, PRESCALE=4): directed table, async reset sequence,
// and random commands checked against a decimal-integer reference model.
module tb_bcd_stopwatch_ctrl;
    import bcd_pkg::*;

    localparam int NDIG     = 2;
    localparam int PRESCALE = 4;
    localparam int W        = 4 * NDIG;
    localparam int MAXV     = 10 ** NDIG - 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVF   = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_stop;
    logic         clear;
    logic         lap;
    logic [W-1:0] count_out;
    logic [W-1:0] disp_out;
    logic         running;
    logic         ovf;
    logic         tick_out;
    state_t       state_dbg;

    bcd_stopwatch_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .count_out  (count_out),
        .disp_out   (disp_out),
        .running    (running),
        .ovf        (ovf),
        .tick_out   (tick_out),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: elapsed time as a plain decimal integer plus a fractional cycle count.
    int m_st, m_frac, m_val, m_lapv;
    bit m_hold;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_frac = 0; m_val = 0; m_lapv = 0; m_hold = 0;
    endtask

    task automatic model_step(input bit ss, input bit cl, input bit lp);
        bit tk;
        int pre_st;
        int pre_val;
        tk      = (m_st == M_RUN) && (m_frac == PRESCALE - 1);
        pre_st  = m_st;
        pre_val = m_val;
        if (cl) begin
            model_reset();
        end else begin
            if (pre_st == M_IDLE && ss) begin
                m_st = M_RUN;
                m_frac = 0;
            end else if (pre_st == M_RUN) begin
                m_frac = (m_frac + 1) % PRESCALE;
                if (tk && m_val == MAXV) begin
                    m_st = M_OVF;
                end else begin
                    if (tk) m_val = m_val + 1;
                    if (ss) m_st = M_PAUSE;
                end
            end else if (pre_st == M_PAUSE && ss) begin
                m_st = M_RUN;
            end
            if (lp && !ss && (pre_st == M_RUN || pre_st == M_PAUSE)) begin
                if (m_hold) begin
                    m_hold = 0;
                end else begin
                    m_hold = 1;
                    m_lapv = pre_val;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " count"}, 32'(count_out), 32'(to_bcd(m_val)));
        chk({tag, " disp"}, 32'(disp_out), 32'(m_hold ? to_bcd(m_lapv) : to_bcd(m_val)));
        chk({tag, " running"}, 32'(running), 32'(m_st == M_RUN));
        chk({tag, " ovf"}, 32'(ovf), 32'(m_st == M_OVF));
        chk({tag, " tick"}, 32'(tick_out), 32'((m_st == M_RUN) && (m_frac == PRESCALE - 1)));
    endtask

    // Inputs are applied for exactly one rising edge, then sampled 1 time unit later.
    task automatic drive_cycle(input bit ss, input bit cl, input bit lp);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        model_step(ss, cl, lp);
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    typedef struct {
        logic         ss;
        logic         cl;
        logic         lp;
        int           idle;
        logic [W-1:0] cnt;
        logic [W-1:0] disp;
        logic         run;
        logic         ov;
        logic         tk;
    } vec_t;

    vec_t tbl[25];

    initial begin
        reset = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        model_reset();

        //         ss cl lp idle  count  disp   run ov tk
        tbl[0]  = '{1, 0, 0, 0,   8'h00, 8'h00, 1, 0, 0};  // start
        tbl[1]  = '{0, 0, 0, 3,   8'h01, 8'h01, 1, 0, 0};  // first tick after 4 edges
        tbl[2]  = '{0, 0, 0, 0,   8'h01, 8'h01, 1, 0, 0};
        tbl[3]  = '{1, 0, 0, 0,   8'h01, 8'h01, 0, 0, 0};  // pause after 6 RUN edges
        tbl[4]  = '{0, 0, 0, 19,  8'h01, 8'h01, 0, 0, 0};  // frozen while paused
        tbl[5]  = '{1, 0, 0, 0,   8'h01, 8'h01, 1, 0, 0};  // resume
        tbl[6]  = '{0, 0, 0, 0,   8'h01, 8'h01, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 0,   8'h02, 8'h02, 1, 0, 0};  // 2 RUN edges after resume
        tbl[8]  = '{0, 0, 0, 39,  8'h12, 8'h12, 1, 0, 0};  // carries across 09 -> 10
        tbl[9]  = '{0, 0, 1, 0,   8'h12, 8'h12, 1, 0, 0};  // lap capture
        tbl[10] = '{0, 0, 0, 11,  8'h15, 8'h12, 1, 0, 0};  // display held
        tbl[11] = '{0, 0, 1, 0,   8'h15, 8'h15, 1, 0, 0};  // release hold
        tbl[12] = '{1, 1, 0, 0,   8'h00, 8'h00, 0, 0, 0};  // clear beats start_stop
        tbl[13] = '{0, 0, 1, 0,   8'h00, 8'h00, 0, 0, 0};  // lap in IDLE ignored
        tbl[14] = '{1, 0, 0, 0,   8'h00, 8'h00, 1, 0, 0};
        tbl[15] = '{0, 0, 0, 11,  8'h03, 8'h03, 1, 0, 0};
        tbl[16] = '{0, 0, 0, 2,   8'h03, 8'h03, 1, 0, 1};
        tbl[17] = '{1, 0, 0, 0,   8'h04, 8'h04, 0, 0, 0};  // pause coincident with tick
        tbl[18] = '{1, 0, 0, 0,   8'h04, 8'h04, 1, 0, 0};
        tbl[19] = '{0, 0, 0, 379, 8'h99, 8'h99, 1, 0, 0};
        tbl[20] = '{0, 0, 0, 3,   8'h99, 8'h99, 0, 1, 0};  // overflow freezes at 99
        tbl[21] = '{1, 0, 0, 0,   8'h99, 8'h99, 0, 1, 0};  // start_stop ignored in OVF
        tbl[22] = '{0, 0, 1, 0,   8'h99, 8'h99, 0, 1, 0};  // lap ignored in OVF
        tbl[23] = '{0, 0, 0, 10,  8'h99, 8'h99, 0, 1, 0};
        tbl[24] = '{0, 0, 0, 0,   8'h99, 8'h99, 0, 1, 0};
        tbl[24].cl   = 1'b1;                                 // clear exits OVF
        tbl[24].cnt  = 8'h00;
        tbl[24].disp = 8'h00;
        tbl[24].ov   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 32'(count_out), 32'h0);
        chk("reset disp", 32'(disp_out), 32'h0);
        chk("reset running", 32'(running), 32'h0);
        chk("reset ovf", 32'(ovf), 32'h0);
        chk("reset tick", 32'(tick_out), 32'h0);
        chk("reset state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive_cycle(tbl[i].ss, tbl[i].cl, tbl[i].lp);
            for (int j = 0; j < tbl[i].idle; j++) drive_cycle(1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d count", i), 32'(count_out), 32'(tbl[i].cnt));
            chk($sformatf("v%0d disp", i), 32'(disp_out), 32'(tbl[i].disp));
            chk($sformatf("v%0d running", i), 32'(running), 32'(tbl[i].run));
            chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(tbl[i].ov));
            chk($sformatf("v%0d tick", i), 32'(tick_out), 32'(tbl[i].tk));
        end

        // Asynchronous reset mid-run, observed before any further clock edge.
        model_reset();
        drive_cycle(1'b1, 1'b0, 1'b0);
        repeat (10) drive_cycle(1'b0, 1'b0, 1'b0);
        check_model("pre-areset");
        drive_cycle(1'b0, 1'b0, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        chk("areset count", 32'(count_out), 32'h0);
        chk("areset disp", 32'(disp_out), 32'h0);
        chk("areset running", 32'(running), 32'h0);
        chk("areset ovf", 32'(ovf), 32'h0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_model("post-areset");

        // Random command stream against the reference model.
        for (int c = 0; c < 4000; c++) begin
            drive_cycle($urandom_range(0, 39) == 0,
                        $urandom_range(0, 1499) == 0,
                        $urandom_range(0, 11) == 0);
            check_model($sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
